// File: rtl/fp_round_normalize_pack.sv
// Final FP encoder: normalizes an extended-precision result, rounds per IEEE-754 mode,
// packs to binary32 and raises flags. Three-stage valid/ready pipeline with global stall.
module fp_round_normalize_pack #(
  parameter int unsigned MANT_W = 50,
  parameter int unsigned EXP_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic              in_sticky,
  input  logic              in_special,
  input  logic [31:0]       in_special_result,
  input  logic              in_invalid,
  input  logic [2:0]        rounding_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out,
  output logic              overflow,
  output logic              underflow,
  output logic              inexact,
  output logic              invalid_operation
);
  localparam int unsigned XW     = EXP_W + 1;
  localparam int unsigned LZW    = $clog2(MANT_W);
  localparam int unsigned FRAC_W = 23;
  localparam logic [2:0]  RNE = 3'b000;
  localparam logic [2:0]  RTZ = 3'b001;
  localparam logic [2:0]  RDN = 3'b010;
  localparam logic [2:0]  RUP = 3'b011;
  localparam logic [2:0]  RMM = 3'b100;
  localparam logic [30:0] MAX_MAG = 31'h7F7F_FFFF;
  localparam logic [30:0] INF_MAG = 31'h7F80_0000;

  typedef struct packed {
    logic              sign;
    logic [XW-1:0]     exp;
    logic [MANT_W-1:0] mant;
    logic              sticky;
    logic              zero;
    logic              special;
    logic [31:0]       sres;
    logic              inv;
    logic [2:0]        mode;
  } s1_t;

  typedef struct packed {
    logic              sign;
    logic [XW-1:0]     exp;
    logic [FRAC_W-1:0] frac;
    logic              inexact;
    logic              zero;
    logic              special;
    logic [31:0]       sres;
    logic              inv;
    logic [2:0]        mode;
  } s2_t;

  logic        stall_c;
  logic        s1_valid_q, s2_valid_q, out_valid_q;
  s1_t         s1_d, s1_q;
  s2_t         s2_d, s2_q;
  logic [31:0] out_d, out_q;
  logic        ov_d, uf_d, nx_d, inv_d;
  logic        ov_q, uf_q, nx_q, inv_q;
  logic [LZW-1:0] lzc;

  assign stall_c  = out_valid_q & ~out_ready;
  assign in_ready = ~stall_c;

  // Leading zeros below the upper integer bit; all-zero yields MANT_W-1.
  always_comb begin
    lzc = LZW'(MANT_W - 1);
    for (int i = 0; i < int'(MANT_W) - 1; i++) begin
      if (in_mant[i]) lzc = LZW'(int'(MANT_W) - 2 - i);
    end
  end

  // S1: normalize so the leading one sits at bit MANT_W-2.
  always_comb begin
    logic [XW-1:0] exp_ext;
    exp_ext         = {in_exp[EXP_W-1], in_exp};
    s1_d            = '0;
    s1_d.special    = in_special;
    s1_d.sres       = in_special_result;
    s1_d.inv        = in_invalid;
    s1_d.mode       = (rounding_mode > RMM) ? RNE : rounding_mode;
    s1_d.zero       = (in_mant == '0) & ~in_sticky;
    s1_d.sign       = s1_d.zero ? (s1_d.mode == RDN) : in_sign;
    s1_d.sticky     = in_sticky;
    if (in_mant[MANT_W-1]) begin
      s1_d.mant   = in_mant >> 1;
      s1_d.sticky = in_sticky | in_mant[0];
      s1_d.exp    = exp_ext + XW'(1);
    end else begin
      s1_d.mant = in_mant << lzc;
      s1_d.exp  = exp_ext - XW'(lzc);
    end
  end

  // S2: round to 23 fraction bits; a carry out renormalizes by bumping the exponent.
  always_comb begin
    logic              g, s, inc;
    logic [FRAC_W:0]   sum;
    g   = s1_q.mant[MANT_W-26];
    s   = (|s1_q.mant[MANT_W-27:0]) | s1_q.sticky;
    case (s1_q.mode)
      RTZ:     inc = 1'b0;
      RDN:     inc = s1_q.sign & (g | s);
      RUP:     inc = ~s1_q.sign & (g | s);
      RMM:     inc = g;
      default: inc = g & (s | s1_q.mant[MANT_W-25]);
    endcase
    sum          = {1'b0, s1_q.mant[MANT_W-3 -: FRAC_W]} + (FRAC_W+1)'(inc);
    s2_d         = '0;
    s2_d.sign    = s1_q.sign;
    s2_d.frac    = sum[FRAC_W-1:0];
    s2_d.exp     = sum[FRAC_W] ? (s1_q.exp + XW'(1)) : s1_q.exp;
    s2_d.inexact = g | s;
    s2_d.zero    = s1_q.zero;
    s2_d.special = s1_q.special;
    s2_d.sres    = s1_q.sres;
    s2_d.inv     = s1_q.inv;
    s2_d.mode    = s1_q.mode;
  end

  // S3: range check, saturate or flush, pack.
  always_comb begin
    out_d = '0;
    ov_d  = 1'b0;
    uf_d  = 1'b0;
    nx_d  = 1'b0;
    inv_d = 1'b0;
    if (s2_q.special) begin
      out_d = s2_q.sres;
      inv_d = s2_q.inv;
    end else if (s2_q.zero) begin
      out_d = {s2_q.sign, 31'b0};
    end else if (!s2_q.exp[XW-1] && (s2_q.exp >= XW'(255))) begin
      ov_d = 1'b1;
      nx_d = 1'b1;
      case (s2_q.mode)
        RTZ:     out_d = {s2_q.sign, MAX_MAG};
        RDN:     out_d = s2_q.sign ? {1'b1, INF_MAG} : {1'b0, MAX_MAG};
        RUP:     out_d = s2_q.sign ? {1'b1, MAX_MAG} : {1'b0, INF_MAG};
        default: out_d = {s2_q.sign, INF_MAG};
      endcase
    end else if (s2_q.exp[XW-1] || (s2_q.exp == '0)) begin
      out_d = {s2_q.sign, 31'b0};
      uf_d  = 1'b1;
      nx_d  = 1'b1;
    end else begin
      out_d = {s2_q.sign, s2_q.exp[7:0], s2_q.frac};
      nx_d  = s2_q.inexact;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s1_q        <= '0;
      s2_q        <= '0;
      out_q       <= '0;
      ov_q        <= 1'b0;
      uf_q        <= 1'b0;
      nx_q        <= 1'b0;
      inv_q       <= 1'b0;
    end else if (!stall_c) begin
      s1_valid_q  <= in_valid;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      out_q       <= out_d;
      ov_q        <= ov_d;
      uf_q        <= uf_d;
      nx_q        <= nx_d;
      inv_q       <= inv_d;
    end
  end

  assign out_valid         = out_valid_q;
  assign out               = out_q;
  assign overflow          = ov_q;
  assign underflow         = uf_q;
  assign inexact           = nx_q;
  assign invalid_operation = inv_q;

endmodule
